// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I core.
// Moore FSM sequencing fetch/decode/execute/memory/writeback.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   op[6:0]            opcode from IR (stable from DECODE on)
//   mem_ready          memory access completes this cycle
//   pc_write, branch   PC load (unconditional / if ALU zero)
//   ir_write           IR / oldPC load
//   adr_src            memory address: 0 PC, 1 ALUOut
//   mem_read/mem_write memory strobes
//   reg_write          register-file write enable
//   alu_src_a/b        ALU operand selects
//   alu_op             00 add, 01 sub, 10 funct-decoded
//   result_src         00 ALUOut, 01 mem data, 10 ALU result
//   imm_src[2:0]       immediate format, decoded from op
//   illegal            high while trapped
//   state_o[3:0]       current state (debug)

module multicycle_control_fsm #(
   parameter bit MEM_WAIT     = 1'b1,
   parameter bit ENABLE_UPPER = 1'b1,
   parameter bit TRAP_HALT    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       branch,
   output logic       ir_write,
   output logic       adr_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic [2:0] imm_src,
   output logic       illegal,
   output logic [3:0] state_o
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_UPPER    = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   state_t r_state;
   state_t w_dec_next;
   logic   w_rdy;
   logic   w_upper;

   assign w_rdy   = MEM_WAIT ? mem_ready : 1'b1;
   assign w_upper = ENABLE_UPPER &&
                    ((op == OP_LUI) || (op == OP_AUIPC));
   assign state_o = r_state;

   always_comb begin
      w_dec_next = S_TRAP;
      case (op)
         OP_LOAD,
         OP_STORE:  w_dec_next = S_MEMADR;
         OP_RTYPE:  w_dec_next = S_EXECR;
         OP_ITYPE:  w_dec_next = S_EXECI;
         OP_JAL:    w_dec_next = S_JAL;
         OP_BRANCH: w_dec_next = S_BEQ;
         default:   w_dec_next = w_upper ? S_UPPER : S_TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    if (w_rdy) r_state <= S_DECODE;
            S_DECODE:   r_state <= w_dec_next;
            S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMREAD
                                                   : S_MEMWRITE;
            S_MEMREAD:  if (w_rdy) r_state <= S_MEMWB;
            S_MEMWB:    r_state <= S_FETCH;
            S_MEMWRITE: if (w_rdy) r_state <= S_FETCH;
            S_EXECR:    r_state <= S_ALUWB;
            S_EXECI:    r_state <= S_ALUWB;
            S_UPPER:    r_state <= S_ALUWB;
            S_ALUWB:    r_state <= S_FETCH;
            S_JAL:      r_state <= S_ALUWB;
            S_BEQ:      r_state <= S_FETCH;
            S_TRAP:     if (!TRAP_HALT) r_state <= S_FETCH;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Outputs decode the state register; reset forces them low
   // immediately so an in-flight write is dropped at once.
   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      illegal    = 1'b0;
      if (rst_n) begin
         case (op)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI,
            OP_AUIPC:  imm_src = ENABLE_UPPER ? 3'b100 : 3'b000;
            default:   imm_src = 3'b000;
         endcase
         case (r_state)
            S_FETCH: begin
               mem_read   = 1'b1;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               ir_write   = w_rdy;
               pc_write   = w_rdy;
            end
            S_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            S_MEMADR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
               adr_src  = 1'b1;
               mem_read = 1'b1;
            end
            S_MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            S_EXECR: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b10;
            end
            S_EXECI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op    = 2'b10;
            end
            S_UPPER: begin
               alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
               alu_src_b = 2'b01;
            end
            S_ALUWB: begin
               reg_write = 1'b1;
            end
            S_JAL: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               pc_write  = 1'b1;
            end
            S_BEQ: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b01;
               branch    = 1'b1;
            end
            S_TRAP: begin
               illegal = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm.
// Two instances: default parameters and ENABLE_UPPER=0/TRAP_HALT=0.

module tb_multicycle_control_fsm;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] BEQ  = 7'b1100011;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] AUI  = 7'b0010111;
   localparam logic [6:0] BAD  = 7'b1111111;
   localparam logic [15:0] STALL_MASK = 16'hA000;

   logic clk = 1'b0;
   logic rst_a, rst_b, mem_ready;
   logic [6:0] op;

   logic pcw_a, br_a, irw_a, adr_a, mr_a, mw_a, rw_a, ill_a;
   logic [1:0] a_a, b_a, alu_a, rs_a;
   logic [2:0] imm_a;
   logic [3:0] st_a;
   logic pcw_b, br_b, irw_b, adr_b, mr_b, mw_b, rw_b, ill_b;
   logic [1:0] a_b, b_b, alu_b, rs_b;
   logic [2:0] imm_b;
   logic [3:0] st_b;

   logic [18:0] obs_a, obs_b;
   assign obs_a = {pcw_a, br_a, irw_a, adr_a, mr_a, mw_a, rw_a,
                   ill_a, a_a, b_a, alu_a, rs_a, imm_a};
   assign obs_b = {pcw_b, br_b, irw_b, adr_b, mr_b, mw_b, rw_b,
                   ill_b, a_b, b_b, alu_b, rs_b, imm_b};

   multicycle_control_fsm dut_a (
      .clk(clk), .rst_n(rst_a), .op(op), .mem_ready(mem_ready),
      .pc_write(pcw_a), .branch(br_a), .ir_write(irw_a),
      .adr_src(adr_a), .mem_read(mr_a), .mem_write(mw_a),
      .reg_write(rw_a), .alu_src_a(a_a), .alu_src_b(b_a),
      .alu_op(alu_a), .result_src(rs_a), .imm_src(imm_a),
      .illegal(ill_a), .state_o(st_a)
   );

   multicycle_control_fsm #(
      .MEM_WAIT(1'b1), .ENABLE_UPPER(1'b0), .TRAP_HALT(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_b), .op(op), .mem_ready(mem_ready),
      .pc_write(pcw_b), .branch(br_b), .ir_write(irw_b),
      .adr_src(adr_b), .mem_read(mr_b), .mem_write(mw_b),
      .reg_write(rw_b), .alu_src_a(a_b), .alu_src_b(b_b),
      .alu_op(alu_b), .result_src(rs_b), .imm_src(imm_b),
      .illegal(ill_b), .state_o(st_b)
   );

   always #5 clk = ~clk;

   int ncmp = 0;
   int nfail = 0;

   typedef struct packed {
      logic [15:0] v;
      logic        w;
   } step_t;
   step_t q[$];

   function automatic logic [15:0] mk(
      logic pcw, logic br, logic irw, logic adr, logic mr,
      logic mw, logic rw, logic ill, logic [1:0] a,
      logic [1:0] b, logic [1:0] alu, logic [1:0] rs);
      return {pcw, br, irw, adr, mr, mw, rw, ill, a, b, alu, rs};
   endfunction

   function automatic logic [2:0] imm_exp(logic [6:0] o, bit eu);
      if (o == SW)  return 3'b001;
      if (o == BEQ) return 3'b010;
      if (o == JAL) return 3'b011;
      if (eu && (o == LUI || o == AUI)) return 3'b100;
      return 3'b000;
   endfunction

   function automatic logic [18:0] obs(bit w);
      return w ? obs_b : obs_a;
   endfunction

   task automatic chk(input string tag, input logic [18:0] o,
                      input logic [18:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected per-cycle output bundles for one instruction.
   task automatic build(input bit eu, input bit th,
                        input logic [6:0] o);
      step_t wb;
      q.delete();
      wb = '{mk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00), 1'b0};
      q.push_back('{mk(1,0,1,0,1,0,0,0,2'b00,2'b10,2'b00,2'b10),
                    1'b1});
      q.push_back('{mk(0,0,0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00),
                    1'b0});
      if (o == LW) begin
         q.push_back('{mk(0,0,0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00),
                       1'b0});
         q.push_back('{mk(0,0,0,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00),
                       1'b1});
         q.push_back('{mk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b01),
                       1'b0});
      end else if (o == SW) begin
         q.push_back('{mk(0,0,0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00),
                       1'b0});
         q.push_back('{mk(0,0,0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00),
                       1'b1});
      end else if (o == RT) begin
         q.push_back('{mk(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00),
                       1'b0});
         q.push_back(wb);
      end else if (o == IT) begin
         q.push_back('{mk(0,0,0,0,0,0,0,0,2'b10,2'b01,2'b10,2'b00),
                       1'b0});
         q.push_back(wb);
      end else if (o == JAL) begin
         q.push_back('{mk(1,0,0,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00),
                       1'b0});
         q.push_back(wb);
      end else if (o == BEQ) begin
         q.push_back('{mk(0,1,0,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00),
                       1'b0});
      end else if (eu && (o == LUI || o == AUI)) begin
         q.push_back('{mk(0,0,0,0,0,0,0,0,
                          (o == LUI) ? 2'b11 : 2'b01,
                          2'b01,2'b00,2'b00), 1'b0});
         q.push_back(wb);
      end else begin
         q.push_back('{mk(0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00),
                       1'b0});
         if (th) begin
            q.push_back(q[q.size()-1]);
            q.push_back(q[q.size()-1]);
         end
      end
   endtask

   // Entered and left at posedge+1 with the DUT in FETCH.
   task automatic run(input bit which, input logic [6:0] o,
                      input string tag);
      bit eu;
      bit th;
      int n;
      logic [2:0] im;
      eu = !which;
      th = !which;
      im = imm_exp(o, eu);
      build(eu, th, o);
      op = o;
      foreach (q[i]) begin
         if (q[i].w) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
               mem_ready = 1'b0;
               @(negedge clk);
               chk({tag, "_stall"}, obs(which),
                   {q[i].v & ~STALL_MASK, im});
               tick();
            end
            mem_ready = 1'b1;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         chk(tag, obs(which), {q[i].v, im});
         tick();
      end
   endtask

   function automatic logic [6:0] pick(bit wild);
      logic [6:0] t[8];
      t = '{LW, SW, RT, IT, JAL, BEQ, LUI, AUI};
      if (wild && $urandom_range(0, 3) == 0)
         return 7'($urandom_range(0, 127));
      return t[$urandom_range(0, 7)];
   endfunction

   logic [18:0] fetch_idle;

   initial begin
      fetch_idle = {mk(0,0,0,0,1,0,0,0,2'b00,2'b10,2'b00,2'b10),
                    3'b000};
      op = 7'd0;
      mem_ready = 1'b0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_outs", obs_a, 19'd0);
      chk("rst_b_outs", obs_b, 19'd0);
      tick();
      rst_a = 1'b1;
      @(negedge clk);
      chk("post_rst_fetch", obs_a, fetch_idle);
      chk("post_rst_state", {15'd0, st_a}, 19'd0);
      tick();

      run(0, LW,  "lw");
      run(0, SW,  "sw");
      run(0, BEQ, "beq");
      run(0, LUI, "lui");
      run(0, AUI, "auipc");
      run(0, RT,  "rtype");
      run(0, IT,  "itype");
      run(0, JAL, "jal");
      repeat (30) run(0, pick(1'b0), "rand_a");

      op = SW;
      mem_ready = 1'b1;
      repeat (3) tick();
      mem_ready = 1'b0;
      @(negedge clk);
      chk("sw_before_rst", {18'd0, mw_a}, 19'd1);
      #1 rst_a = 1'b0;
      #1;
      chk("sw_rst_drop", obs_a, 19'd0);
      tick();
      rst_a = 1'b1;
      @(negedge clk);
      chk("sw_rst_fetch", obs_a,
          {mk(0,0,0,0,1,0,0,0,2'b00,2'b10,2'b00,2'b10), 3'b001});
      tick();
      run(0, LW, "lw_after_rst");

      run(0, BAD, "trap_halt");
      rst_a = 1'b0;
      tick();

      rst_b = 1'b1;
      run(1, LUI, "lui_noupper");
      run(1, AUI, "auipc_noupper");
      run(1, BAD, "trap_once");
      run(1, SW,  "sw_b");
      repeat (30) run(1, pick(1'b1), "rand_b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nfail);
      $finish;
   end

endmodule
